// File: rtl/instr_rom_loader_pkg.sv
// rom_loader_pkg: shared FSM state type and defaults for the instruction ROM loader
package rom_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} loader_state_t;
  localparam int ROM_DEPTH = 256;
  localparam logic [7:0] NOP_OPCODE_DEF = 8'h00;
endpackage

// File: rtl/instr_rom_loader_if.sv
// instr_rom_loader_if: program-load stream (load_start/load_len request, ld_valid/ld_data/ld_ready byte handshake); master = program source, slave = loader
interface instr_rom_loader_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic load_start;
  logic [ADDR_W-1:0] load_len;
  logic ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic ld_ready;
  modport master (output load_start, load_len, ld_valid, ld_data, input ld_ready);
  modport slave (input load_start, load_len, ld_valid, ld_data, output ld_ready);
endinterface

// File: rtl/instr_rom_loader_rom.sv
// prog_rom_256x8: program memory; ports clk, we/wa/wd sync write, a -> rd0=mem[a], rd1=mem[a+1] async (wrapping)
module prog_rom_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] a1;
  assign a1 = a + ADDR_W'(1);
  assign rd0 = mem[a];
  assign rd1 = mem[a1];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
endmodule

// File: rtl/instr_rom_loader.sv
// instr_rom_loader: loads a program over ld (slave), holds cpu_reset until done, then serves opcode1/opcode2 for rom_address; pulses load_done
module instr_rom_loader import rom_loader_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] NOP_OPCODE = NOP_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  instr_rom_loader_if.slave ld,
  input  logic [ADDR_W-1:0] rom_address,
  output logic [DATA_W-1:0] opcode1,
  output logic [DATA_W-1:0] opcode2,
  output logic              cpu_reset,
  output logic              load_done
);
  localparam int CNT_W = ADDR_W + 1;
  loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic ld_ready_q, ld_ready_d, cpu_reset_q, cpu_reset_d, load_done_q, load_done_d;
  logic wr_en;
  logic [DATA_W-1:0] rd0, rd1;
  assign wr_en = ld_ready_q & ld.ld_valid & ~reset;
  prog_rom_256x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk(clk), .we(wr_en), .wa(wr_ptr_q), .wd(ld.ld_data), .a(rom_address), .rd0(rd0), .rd1(rd1)
  );
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    remaining_d = remaining_q;
    load_done_d = 1'b0;
    if (state_q != LOAD && ld.load_start) begin
      state_d = LOAD;
      wr_ptr_d = '0;
      remaining_d = (ld.load_len == '0) ? CNT_W'(2**ADDR_W) : CNT_W'(ld.load_len);
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
      state_d = (remaining_q == CNT_W'(1)) ? RUN : LOAD;
      load_done_d = (remaining_q == CNT_W'(1));
    end
    ld_ready_d = (state_d == LOAD);
    cpu_reset_d = (state_d != RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      remaining_q <= '0;
      ld_ready_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      remaining_q <= remaining_d;
      ld_ready_q <= ld_ready_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
    end
  end
  assign ld.ld_ready = ld_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign opcode1 = (state_q == RUN) ? rd0 : NOP_OPCODE;
  assign opcode2 = (state_q == RUN) ? rd1 : NOP_OPCODE;
endmodule

// File: doc/instr_rom_loader.md
# instr_rom_loader

- Instruction-side responder for the 8-bit CPU: it owns the 256x8 program memory and answers every `rom_address` with the two-byte instruction (`opcode1`, `opcode2`).
- Before execution it accepts a program as a byte stream over a valid/ready handshake and holds the CPU in reset.
- Once the last byte is stored it releases the CPU and serves fetches combinationally.
- It sits between the external program source (testbench or host link) and the CPU's `opcode1`/`opcode2`/`rom_address`/`reset` pins.

## Interface
Parameters:
- ADDR_W, 8, program memory address width (depth = 2**ADDR_W = 256)
- DATA_W, 8, byte width
- NOP_OPCODE, 8'h00, value driven on `opcode1`/`opcode2` whenever not in RUN

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  single-cycle request to begin a program load
- load_len  in  8  number of bytes to load, sampled with `load_start`; 0 means 256
- ld_valid  in  1  `ld_data` is valid
- ld_data  in  8  program byte
- ld_ready  out  1  loader accepts a byte this cycle
- rom_address  in  8  CPU fetch address
- opcode1  out  8  mem[rom_address]
- opcode2  out  8  mem[rom_address+1], wrapping 255->0
- cpu_reset  out  1  drives the CPU `reset`; high except in RUN
- load_done  out  1  one-cycle pulse after the final byte is written

## Operation
- States:
  - IDLE: no loading, CPU held in reset.
  - LOAD: `ld_ready=1`.
  - RUN: `cpu_reset=0`, fetches served.
- Transitions:
  - IDLE -> LOAD on `load_start`. Latch `remaining = (load_len==0) ? 256 : load_len` (9-bit), `wr_ptr = 0`.
  - RUN -> LOAD on `load_start`, with the same latch. The CPU is re-held in reset.
  - LOAD: a byte transfers when `ld_valid && ld_ready`. It writes mem[wr_ptr], increments `wr_ptr` (8-bit, wraps) and decrements `remaining`.
  - LOAD -> RUN on the transfer that takes `remaining` from 1 to 0.
  - `load_start` during LOAD is ignored. The load in progress continues.
- Fetch: read is combinational and asynchronous. `opcode2` address is `rom_address+1` truncated to 8 bits.
- Outputs in IDLE/LOAD: `opcode1 = opcode2 = NOP_OPCODE`. The CPU decodes 8'h00 as no-op.
- Memory is not cleared by reset. Bytes beyond the loaded length keep their previous contents.
- Reset mid-load: return to IDLE immediately. Bytes already written stay in memory. No `load_done` pulse.

## Timing
- Reset values: state=IDLE, `ld_ready=0`, `cpu_reset=1`, `load_done=0`, `opcode1=opcode2=NOP_OPCODE`, `wr_ptr=0`, `remaining=0`.
- All control outputs (`ld_ready`, `cpu_reset`, `load_done`) are registered.
- `ld_ready` rises the cycle after `load_start` is sampled. It falls the cycle after the final transfer.
- Throughput: one byte per cycle while `ld_valid` is held.
- A byte written at edge N is readable via the fetch port from cycle N+1.
- The final byte at edge N gives, at cycle N+1:
  - state=RUN
  - `cpu_reset=0`
  - `load_done=1` for exactly one cycle
  - opcodes reflect memory, including that byte
- Fetch latency: zero cycles. `opcode1`/`opcode2` follow `rom_address` combinationally in RUN.
- `cpu_reset` rises the cycle after `load_start` is sampled in RUN.

## Structure
- Package `rom_loader_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, RUN} loader_state_t`
  - `ROM_DEPTH = 256`
  - `NOP_OPCODE_DEF = 8'h00`
- Sub-module `prog_rom_256x8`: one synchronous write port and two asynchronous read ports, addresses `a` and `a+1`.
- Top level holds the FSM, the counters and the output muxing.

## Test plan
- Reset held 2 cycles → `cpu_reset=1`, `ld_ready=0`, `opcode1=opcode2=8'h00`, `load_done=0`.
- `load_start` with `load_len=4`, then bytes 8'h10,8'h05,8'h11,8'h03 on consecutive cycles:
  - `ld_ready` high for 4 transfers
  - then `load_done` pulses once and `cpu_reset` falls
  - `rom_address=0` → 8'h10/8'h05
  - `rom_address=2` → 8'h11/8'h03
- `ld_valid` toggling 1,0,0,1,1 with `load_len=3`:
  - exactly 3 bytes written, to addresses 0,1,2
  - RUN entered the cycle after the third transfer
- `load_len=0`, 256 bytes with value = index:
  - `load_done` after the 256th transfer
  - `rom_address=8'hFF` → `opcode1=8'hFF`, `opcode2=8'h00` (wrap)
- Reset after 2 of 4 bytes:
  - state IDLE, `ld_ready=0`, no `load_done`
  - a new load of 1 byte 8'hAA gives `rom_address=0` → 8'hAA, `opcode2` = previously written 8'h05
- `load_start` in RUN with `load_len=2`:
  - `cpu_reset` high next cycle, opcodes 8'h00
  - new bytes overwrite addresses 0-1
  - `load_start` pulsed mid-load is ignored (`wr_ptr` unaffected)
